// File: rtl/rom_loader.sv
// Boot-time loader: assembles a byte stream into little-endian words, writes them to
// instruction memory and holds the core until done. Optional trailer check: ROM_LOADER_CHECKSUM_EN.
module rom_loader #(
  parameter int unsigned ADDR_W     = 12,
  parameter logic [31:0] START_ADDR = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [ADDR_W:0]   len_i,
  input  logic              byte_valid_i,
  input  logic [7:0]        byte_data_i,
  output logic              byte_ready_o,
  output logic              mem_we_o,
  output logic [31:0]       mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic              cpu_hold_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  localparam logic [ADDR_W:0] CAP  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] ZERO = {(ADDR_W+1){1'b0}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DONE  = 2'd2
`ifdef ROM_LOADER_CHECKSUM_EN
    , S_CHECK = 2'd3
`endif
  } state_e;

  state_e          state_q, state_d;
  logic [ADDR_W:0] len_q, len_d;
  logic [ADDR_W:0] idx_q, idx_d;
  logic [1:0]      bcnt_q, bcnt_d;
  logic [23:0]     asm_q, asm_d;
  logic            byte_ready_q, byte_ready_d;
  logic            mem_we_q, mem_we_d;
  logic [31:0]     mem_addr_q, mem_addr_d;
  logic [31:0]     mem_wdata_q, mem_wdata_d;
  logic            cpu_hold_q, cpu_hold_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            accept_s, word_done_s, last_word_s, err_next_s;
  logic [31:0]     word_s;
`ifdef ROM_LOADER_CHECKSUM_EN
  logic            err_q, err_d;
  logic [31:0]     sum_q, sum_d;
`endif

  // Next-state, byte assembly and registered-output computation
  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    idx_d        = idx_q;
    bcnt_d       = bcnt_q;
    asm_d        = asm_q;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    last_word_s  = 1'b0;
`ifdef ROM_LOADER_CHECKSUM_EN
    err_d        = err_q;
    sum_d        = sum_q;
`endif
    accept_s     = byte_ready_q & byte_valid_i;
    word_s       = {byte_data_i, asm_q};
    word_done_s  = accept_s && (bcnt_q == 2'd3);

    if (accept_s) begin
      bcnt_d = bcnt_q + 2'd1;
      case (bcnt_q)
        2'd0:    asm_d[7:0]   = byte_data_i;
        2'd1:    asm_d[15:8]  = byte_data_i;
        2'd2:    asm_d[23:16] = byte_data_i;
        default: asm_d        = asm_q;
      endcase
    end else begin
      bcnt_d = bcnt_q;
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          len_d  = (len_i > CAP) ? CAP : len_i;
          idx_d  = ZERO;
          bcnt_d = 2'd0;
`ifdef ROM_LOADER_CHECKSUM_EN
          err_d  = 1'b0;
          sum_d  = 32'h0000_0000;
          state_d = (len_d == ZERO) ? S_CHECK : S_LOAD;
`else
          state_d = (len_d == ZERO) ? S_DONE : S_LOAD;
`endif
        end else begin
          state_d = state_q;
        end
      end
      S_LOAD: begin
        if (word_done_s) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = START_ADDR + {{(30-ADDR_W){1'b0}}, idx_q[ADDR_W-1:0], 2'b00};
          mem_wdata_d = word_s;
          idx_d       = idx_q + ONE;
          // ready must already be low in the cycle that carries the final write
          last_word_s = ((idx_q + ONE) == len_q);
`ifdef ROM_LOADER_CHECKSUM_EN
          sum_d       = sum_q + word_s;
`endif
        end else begin
          mem_we_d    = 1'b0;
        end
        if (mem_we_q && (idx_q == len_q)) begin
`ifdef ROM_LOADER_CHECKSUM_EN
          state_d = S_CHECK;
`else
          state_d = S_DONE;
`endif
        end else begin
          state_d = state_q;
        end
      end
`ifdef ROM_LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (word_done_s) begin
          state_d = S_DONE;
          err_d   = (word_s != sum_q);
        end else begin
          state_d = state_q;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

`ifdef ROM_LOADER_CHECKSUM_EN
    err_next_s   = err_d;
    busy_d       = (state_d == S_LOAD) || (state_d == S_CHECK);
    byte_ready_d = ((state_d == S_LOAD) && !last_word_s) || (state_d == S_CHECK);
`else
    err_next_s   = 1'b0;
    busy_d       = (state_d == S_LOAD);
    byte_ready_d = (state_d == S_LOAD) && !last_word_s;
`endif
    done_d       = (state_d == S_DONE);
    cpu_hold_d   = !((state_d == S_DONE) && !err_next_s);
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      len_q        <= ZERO;
      idx_q        <= ZERO;
      bcnt_q       <= 2'd0;
      asm_q        <= 24'h00_0000;
      byte_ready_q <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= START_ADDR;
      mem_wdata_q  <= 32'h0000_0000;
      cpu_hold_q   <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef ROM_LOADER_CHECKSUM_EN
      err_q        <= 1'b0;
      sum_q        <= 32'h0000_0000;
`endif
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      idx_q        <= idx_d;
      bcnt_q       <= bcnt_d;
      asm_q        <= asm_d;
      byte_ready_q <= byte_ready_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      cpu_hold_q   <= cpu_hold_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
`ifdef ROM_LOADER_CHECKSUM_EN
      err_q        <= err_d;
      sum_q        <= sum_d;
`endif
    end
  end

  assign byte_ready_o = byte_ready_q;
  assign mem_we_o     = mem_we_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;
  assign cpu_hold_o   = cpu_hold_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
`ifdef ROM_LOADER_CHECKSUM_EN
  assign err_o        = err_q;
`else
  assign err_o        = 1'b0;
`endif

endmodule

// File: tb/tb_rom_loader.sv
// Randomized scoreboard bench for rom_loader; expected writes come from a word-list model.
module tb_rom_loader;
  localparam int          AW  = 3;
  localparam int          CAP = 8;
  localparam logic [31:0] SA  = 32'h0000_0400;

  logic        clk, rst, start_i, byte_valid_i;
  logic [AW:0] len_i;
  logic [7:0]  byte_data_i;
  logic        byte_ready_o, mem_we_o, cpu_hold_o, busy_o, done_o, err_o;
  logic [31:0] mem_addr_o, mem_wdata_o;

  rom_loader #(.ADDR_W(AW), .START_ADDR(SA)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .len_i(len_i),
    .byte_valid_i(byte_valid_i), .byte_data_i(byte_data_i), .byte_ready_o(byte_ready_o),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .cpu_hold_o(cpu_hold_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] addr; logic [31:0] data; } wr_t;
  wr_t  exp_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  logic we_prev = 1'b0;

  task automatic check(input string name, input logic [69:0] act, input logic [69:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset(input string name);
    check(name, {byte_ready_o, mem_we_o, mem_addr_o, mem_wdata_o, cpu_hold_o, busy_o, done_o, err_o},
          {1'b0, 1'b0, SA, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0});
  endtask

  // Monitor: every write pulse is matched against the scoreboard queue
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (!rst && mem_we_o) begin
        check("write_single_cycle", {69'd0, we_prev}, 70'd0);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_write: got addr %h data %h, expected no write", mem_addr_o, mem_wdata_o);
        end else begin
          e = exp_q.pop_front();
          check("write", {6'd0, mem_addr_o, mem_wdata_o}, {6'd0, e.addr, e.data});
        end
      end
      we_prev = mem_we_o && !rst;
    end
  end

  // Offers bytes; counts how many the loader takes (ready is stable until the next rising edge)
  task automatic drive(input logic [7:0] b[$], input int needed, input int mode, output int acc);
    int i;
    bit v;
    i = 0;
    acc = 0;
    for (int cyc = 0; cyc < 3*needed + 20 && i < b.size(); cyc++) begin
      @(negedge clk);
      v = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : ($urandom_range(0, 3) != 0);
      byte_valid_i = v;
      byte_data_i  = b[i];
      if (v && byte_ready_o) begin
        i++;
        acc++;
      end
    end
    @(negedge clk);
    byte_valid_i = 1'b0;
  endtask

  task automatic run_load(input int len, input logic [31:0] w[$], input int mode, input bit bad);
    int          eff, needed, acc;
    logic [31:0] sum, tr;
    logic [7:0]  b[$];
    bit          exp_err;
    wr_t         e;
    eff = (len > CAP) ? CAP : len;
    sum = 32'h0;
    for (int i = 0; i < eff; i++) begin
      e.addr = SA + 32'(4*i);
      e.data = w[i];
      exp_q.push_back(e);
      sum = sum + w[i];
      for (int k = 0; k < 4; k++) b.push_back(w[i][8*k +: 8]);
    end
`ifdef ROM_LOADER_CHECKSUM_EN
    tr = sum + (bad ? 32'd1 : 32'd0);
    for (int k = 0; k < 4; k++) b.push_back(tr[8*k +: 8]);
    exp_err = bad;
`else
    tr = sum;
    exp_err = 1'b0;
`endif
    needed = b.size();
    b.push_back(8'($urandom));
    b.push_back(8'($urandom));
    @(negedge clk);
    start_i = 1'b1;
    len_i   = (AW+1)'(len);
    @(negedge clk);
    start_i = 1'b0;
    if (needed == 0)
      check("len0_done_next_cycle", {67'd0, done_o, cpu_hold_o, busy_o}, {67'd0, 1'b1, 1'b0, 1'b0});
    else
      check("load_entry", {66'd0, busy_o, cpu_hold_o, done_o, byte_ready_o}, {66'd0, 4'b1101});
    drive(b, needed, mode, acc);
    check("bytes_consumed", 70'(acc), 70'(needed));
    check("final_state", {65'd0, done_o, busy_o, byte_ready_o, cpu_hold_o, err_o},
          {65'd0, 1'b1, 1'b0, 1'b0, exp_err, exp_err});
    check("all_writes_seen", 70'(exp_q.size()), 70'd0);
  endtask

  initial begin
    logic [31:0] w[$];
    logic [7:0]  b5[$];
    wr_t         e;
    int          acc;
    rst = 1'b0; start_i = 1'b0; len_i = '0; byte_valid_i = 1'b0; byte_data_i = 8'h00;
    #1 rst = 1'b1;
    #2 check_reset("reset_values");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    w = '{32'h1234_5678, 32'hDEAD_BEEF};
    run_load(2, w, 0, 1'b0);
    run_load(2, w, 1, 1'b0);
    w = '{};
    run_load(0, w, 0, 1'b0);

    // reset in the middle of a 3-word load, after 5 bytes
    @(negedge clk);
    start_i = 1'b1;
    len_i   = (AW+1)'(3);
    @(negedge clk);
    start_i = 1'b0;
    e.addr = SA;
    e.data = 32'h4433_2211;
    exp_q.push_back(e);
    b5 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    drive(b5, 5, 0, acc);
    check("midload_bytes", 70'(acc), 70'd5);
    #2 rst = 1'b1;
    #1 check_reset("midload_reset_values");
    check("midload_writes_seen", 70'(exp_q.size()), 70'd0);
    @(negedge clk);
    rst = 1'b0;
    w = '{32'hCAFE_F00D};
    run_load(1, w, 0, 1'b0);

    w = '{32'h0000_0001};
    run_load(1, w, 0, 1'b0);

    w = '{32'h0000_0001, 32'h0000_0002};
    run_load(2, w, 0, 1'b0);
    run_load(2, w, 0, 1'b1);

    w = '{};
    for (int i = 0; i < CAP; i++) w.push_back($urandom);
    run_load(12, w, 2, 1'b0);

    for (int it = 0; it < 8; it++) begin
      w = '{};
      for (int i = 0; i < CAP; i++) w.push_back($urandom);
      run_load(int'($urandom_range(0, 15)), w, int'($urandom_range(0, 2)), bit'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/rom_loader.md
Name: rom_loader

Overview:
- Boot-time writer for the instruction memory that the core fetches from; the core only ever reads that memory.
- Accepts a byte stream over a valid/ready handshake.
- Assembles bytes little-endian into 32-bit words and issues single-cycle word writes at sequential byte addresses.
- Holds the core in reset until the programmed word count has been written.

Parameters:
- ADDR_W, 12, word-index width; capacity is 2^ADDR_W words.
- START_ADDR, 32'h0000_0000, byte address of the first word written; must be 4-byte aligned.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- start_i  input  1  begin a load; sampled in IDLE and DONE only.
- len_i  input  ADDR_W+1  number of words to load; sampled on start_i.
- byte_valid_i  input  1  byte_data_i holds a valid byte.
- byte_data_i  input  8  stream byte.
- byte_ready_o  output  1  loader accepts a byte this cycle.
- mem_we_o  output  1  one-cycle write strobe to instruction memory.
- mem_addr_o  output  32  byte address of the write.
- mem_wdata_o  output  32  word to write.
- cpu_hold_o  output  1  drives the core reset/hold; 1 = core held.
- busy_o  output  1  high in LOAD (and CHECK, if compiled in).
- done_o  output  1  high in DONE.
- err_o  output  1  checksum mismatch; tied 0 when the feature is compiled out.

Behaviour:
- Reset values (asynchronous): state IDLE, byte_ready_o=0, mem_we_o=0, mem_addr_o=START_ADDR, mem_wdata_o=0, cpu_hold_o=1, busy_o=0, done_o=0, err_o=0, byte counter 0, word index 0.
- States: IDLE, LOAD, DONE (plus CHECK with the optional feature).
- IDLE:
  - start_i=1 latches len_i.
  - Values above 2^ADDR_W are clamped to 2^ADDR_W.
  - If latched length = 0, go to DONE next cycle; otherwise go to LOAD.
- LOAD:
  - byte_ready_o=1 every cycle; no backpressure.
  - A byte is accepted when byte_valid_i && byte_ready_o.
  - The k-th accepted byte of a word (k=0..3) goes to bits [8k+7:8k].
- Word write:
  - On acceptance of byte 3, the assembled word is registered.
  - The following cycle, mem_we_o=1 for exactly one cycle, with mem_addr_o = START_ADDR + 4*index and mem_wdata_o = word.
  - The index then increments.
  - Byte acceptance continues in the write cycle; the assembly register is independent of the output registers.
- Leaving LOAD: on the cycle mem_we_o carries the last word (index = length-1), the next state is DONE (or CHECK).
  - byte_ready_o drops in that same cycle.
  - Bytes offered afterwards are not consumed.
- DONE:
  - done_o=1.
  - cpu_hold_o=0 (stays 1 if err_o=1).
  - byte_ready_o=0.
  - start_i=1 restarts: next cycle cpu_hold_o=1, done_o=0, err_o cleared, index and byte counter reset to 0, new len_i latched.
- start_i in LOAD/CHECK: ignored.
- Index wrap: at 2^ADDR_W words, the address would reach START_ADDR + 4*2^ADDR_W; clamping of len_i guarantees this is never written.
- A partial word (fewer than 4 bytes) is never written.
- mem_we_o is only ever a single-cycle pulse; it is never asserted outside LOAD-derived write cycles.
- rst asserted mid-load: everything returns to reset values immediately; the partially loaded memory contents are left as is.

Optional Feature:
- Macro: ROM_LOADER_CHECKSUM_EN.
- With the macro defined:
  - A running 32-bit sum (mod 2^32) of all written words is kept.
  - After the last word write, the loader goes to CHECK and accepts exactly one further 4-byte little-endian word, which is not written to memory.
  - On its 4th byte the loader goes to DONE; err_o = (received != sum).
  - If err_o=1, cpu_hold_o remains 1 in DONE.
  - For length 0, CHECK is still entered; the expected sum is 0.
- Without the macro: no CHECK state, err_o constant 0, no extra word consumed.

Test Plan:
- Reset, len_i=2, start_i pulse, bytes 78 56 34 12 EF BE AD DE, valid every cycle -> two mem_we_o pulses:
  - addr 0x0 data 0x12345678;
  - addr 0x4 data 0xDEADBEEF.
  - Then done_o=1, cpu_hold_o=0.
- Same stream with byte_valid_i toggling every other cycle -> identical writes, no bytes lost, each write exactly one cycle.
- len_i=0 -> DONE one cycle after start, no mem_we_o, cpu_hold_o=0.
- rst asserted after 5 bytes of a 3-word load -> all outputs at reset values immediately; a fresh start with len_i=1 writes address 0x0.
- Restart from DONE with len_i=1, bytes 01 00 00 00 -> cpu_hold_o=1 during the load, write addr 0x0 data 0x00000001, then DONE.
- With ROM_LOADER_CHECKSUM_EN, load words 0x00000001 and 0x00000002:
  - trailer 0x00000003 -> err_o=0, cpu_hold_o=0;
  - trailer 0x00000004 -> err_o=1, cpu_hold_o=1.
